// File: rtl/instr_encoder_loader.sv
// Packs decoded instruction fields into 32-bit words and streams them to instruction memory.
// Optional: define ENCODER_ERR_HALT_EN to drop unencodable sets and halt instead of writing NOP.
module instr_encoder_loader #(
  parameter int unsigned NUM_REG       = 32,
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned ADDR_WIDTH    = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
  localparam int unsigned OPCODES_WIDTH = 4,
  localparam int unsigned REG_SELECT    = $clog2(NUM_REG)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [OPCODES_WIDTH-1:0] i_opcode,
  input  logic [REG_SELECT-1:0]    i_sel_a,
  input  logic [REG_SELECT-1:0]    i_sel_b,
  input  logic [REG_SELECT-1:0]    i_sel_c,
  input  logic [31:0]              i_offset,
  input  logic                     i_last,
  output logic                     o_mem_we,
  output logic [ADDR_WIDTH-1:0]    o_mem_addr,
  output logic [31:0]              o_mem_wdata,
  input  logic                     i_mem_ready,
  output logic [ADDR_WIDTH-1:0]    o_count,
  output logic                     o_done,
  output logic                     o_error
);

  localparam int unsigned IMM_W = 32 - OPCODES_WIDTH - 2 * REG_SELECT;
  localparam int unsigned LOW_W = IMM_W - REG_SELECT;
  localparam int unsigned JMP_W = 32 - OPCODES_WIDTH;
  localparam int unsigned PW    = $clog2(FIFO_DEPTH);

  typedef enum logic [OPCODES_WIDTH-1:0] {
    NOP_OP = 4'd0, ADD_OP = 4'd1, SUB_OP = 4'd2, AND_OP = 4'd3, OR_OP = 4'd4,
    MUL_OP = 4'd5, DIV_OP = 4'd6, XOR_OP = 4'd7, LW_OP = 4'd8, SW_OP = 4'd9,
    BEQ_OP = 4'd10, BLT_OP = 4'd11, BLE_OP = 4'd12, JMP_OP = 4'd13
  } opcodes_e;

`ifdef ENCODER_ERR_HALT_EN
  typedef enum logic [1:0] {StRun, StFlush, StDone, StHalt} state_e;
`else
  typedef enum logic [1:0] {StRun, StFlush, StDone} state_e;
`endif

  state_e                  state_q, state_d;
  logic                    enc_valid_q, enc_valid_d;
  logic [31:0]             enc_word_q, enc_word_d;
  logic [PW:0]             wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d, count_q, count_d;
  logic                    error_q, error_d, restart_q, restart_d;
  logic [31:0]             fifo_mem [FIFO_DEPTH];

  logic signed [31:0] off_sh, imm_sx, br_sx, jmp_sx;
  logic        fits_imm, fits_br, fits_jmp, enc_bad;
  logic [31:0] enc_word, head;
  logic [PW:0] fifo_cnt;
  logic        fifo_empty, fifo_full, accept, mem_we, wr_done;
  logic        pop_fifo, take_stage, push, load_stage;

  // Range checks: a value fits signed N bits iff sign-extending its low N bits reproduces it.
  always_comb begin
    off_sh   = $signed(i_offset) >>> 2;
    imm_sx   = {{(32-IMM_W){i_offset[IMM_W-1]}}, i_offset[IMM_W-1:0]};
    br_sx    = {{(32-IMM_W){off_sh[IMM_W-1]}}, off_sh[IMM_W-1:0]};
    jmp_sx   = {{(32-JMP_W){off_sh[JMP_W-1]}}, off_sh[JMP_W-1:0]};
    fits_imm = (imm_sx == $signed(i_offset));
    fits_br  = (br_sx == off_sh) && (i_offset[1:0] == 2'b00);
    fits_jmp = (jmp_sx == off_sh) && (i_offset[1:0] == 2'b00);
  end

  always_comb begin
    enc_word = '0;
    enc_bad  = 1'b0;
    case (i_opcode)
      ADD_OP, SUB_OP, AND_OP, OR_OP, MUL_OP, DIV_OP, XOR_OP:
        enc_word = {i_opcode, i_sel_a, i_sel_b, i_sel_c, {LOW_W{1'b0}}};
      LW_OP: begin
        enc_word = {i_opcode, i_sel_a, i_offset[IMM_W-1 -: REG_SELECT], i_sel_c,
                    i_offset[LOW_W-1:0]};
        enc_bad  = !fits_imm;
      end
      SW_OP: begin
        enc_word = {i_opcode, i_sel_a, i_sel_b, i_offset[IMM_W-1:0]};
        enc_bad  = !fits_imm;
      end
      BEQ_OP, BLT_OP, BLE_OP: begin
        enc_word = {i_opcode, i_sel_a, i_sel_b, off_sh[IMM_W-1:0]};
        enc_bad  = !fits_br;
      end
      JMP_OP: begin
        enc_word = {i_opcode, off_sh[JMP_W-1:0]};
        enc_bad  = !fits_jmp;
      end
      NOP_OP:  enc_word = '0;
      default: enc_bad = 1'b1;
    endcase
    if (enc_bad) enc_word = '0;
  end

  // The encode stage acts as an extra slot behind the FIFO, so total buffering is FIFO_DEPTH+1.
  always_comb begin
    fifo_cnt   = wr_ptr_q - rd_ptr_q;
    fifo_empty = (fifo_cnt == '0);
    fifo_full  = (fifo_cnt == (PW+1)'(FIFO_DEPTH));
    o_ready    = !rst && (state_q == StRun) && !(enc_valid_q && fifo_full);
    accept     = i_valid && o_ready;
    mem_we     = !fifo_empty || enc_valid_q;
    head       = fifo_empty ? enc_word_q : fifo_mem[rd_ptr_q[PW-1:0]];
    wr_done    = mem_we && i_mem_ready;
    pop_fifo   = wr_done && !fifo_empty;
    take_stage = wr_done && fifo_empty;
    push       = enc_valid_q && !take_stage && !fifo_full;
`ifdef ENCODER_ERR_HALT_EN
    load_stage = accept && !enc_bad;
`else
    load_stage = accept;
`endif
  end

  always_comb begin
    state_d     = state_q;
    enc_valid_d = enc_valid_q && !take_stage && !push;
    enc_word_d  = enc_word_q;
    wr_ptr_d    = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d    = pop_fifo ? rd_ptr_q + 1'b1 : rd_ptr_q;
    addr_d      = wr_done ? addr_q + ADDR_WIDTH'(4) : addr_q;
    count_d     = count_q;
    error_d     = error_q || (accept && enc_bad);
    restart_d   = restart_q;
    o_done      = 1'b0;
    if (load_stage) begin
      enc_valid_d = 1'b1;
      enc_word_d  = enc_word;
    end
    if (accept) begin
      restart_d = 1'b0;
      if (restart_q) count_d = '0;
    end
    if (wr_done) count_d = count_q + ADDR_WIDTH'(1);
    case (state_q)
      StRun: begin
        if (accept && i_last) state_d = StFlush;
`ifdef ENCODER_ERR_HALT_EN
        if (accept && enc_bad) state_d = StHalt;
`endif
      end
      StFlush: if (fifo_empty && !enc_valid_q) state_d = StDone;
      StDone: begin
        o_done    = 1'b1;
        addr_d    = BASE_ADDR;
        restart_d = 1'b1;
        state_d   = StRun;
      end
`ifdef ENCODER_ERR_HALT_EN
      StHalt: state_d = StHalt;
`endif
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StRun;
      enc_valid_q <= 1'b0;
      enc_word_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      addr_q      <= BASE_ADDR;
      count_q     <= '0;
      error_q     <= 1'b0;
      restart_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      enc_valid_q <= enc_valid_d;
      enc_word_q  <= enc_word_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      addr_q      <= addr_d;
      count_q     <= count_d;
      error_q     <= error_d;
      restart_q   <= restart_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q[PW-1:0]] <= enc_word_q;
  end

  assign o_mem_we    = mem_we;
  assign o_mem_addr  = addr_q;
  assign o_mem_wdata = mem_we ? head : '0;
  assign o_count     = count_q;
  assign o_error     = error_q;

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
- Inverse of the 32-bit opcode decoder. Takes decoded instruction fields (opcode, register selects, byte offset) over a valid/ready handshake and packs them into 32-bit instruction words in the decoder's field layout.
- Buffers encoded words in a small FIFO and streams them into instruction memory at sequential word addresses.
- Used by the testbench/boot path to load programs into the CBS core.

Parameters:
- NUM_REG, 32, register file size; REG_SELECT = $clog2(NUM_REG).
- FIFO_DEPTH, 4, encoded-word buffer depth (power of 2, >= 2).
- ADDR_WIDTH, 32, instruction memory address width.
- BASE_ADDR, 0, byte address of the first written word.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- i_valid  in  1  field set valid.
- o_ready  out  1  field set accepted when i_valid && o_ready.
- i_opcode  in  OPCODES_WIDTH  opcodes_e value.
- i_sel_a  in  REG_SELECT  A field.
- i_sel_b  in  REG_SELECT  B field.
- i_sel_c  in  REG_SELECT  C field.
- i_offset  in  32  signed byte offset.
- i_last  in  1  marks final instruction of the program.
- o_mem_we  out  1  write request.
- o_mem_addr  out  ADDR_WIDTH  byte address.
- o_mem_wdata  out  32  encoded word.
- i_mem_ready  in  1  memory accepts write this cycle.
- o_count  out  ADDR_WIDTH  words written since last program start.
- o_done  out  1  one-cycle pulse: program fully written.
- o_error  out  1  sticky: a field set was not encodable.

Behaviour:
- Field layout (IMM_W = 32 - OPCODES_WIDTH - 2*REG_SELECT):
  - opcode at [31 -: OPCODES_WIDTH].
  - A at next REG_SELECT bits, then B.
  - imm at [IMM_W-1:0]; C = imm[IMM_W-1 -: REG_SELECT].
- Per opcode (unused bits = 0):
  - ALU ops (ADD, SUB, AND, OR, MUL, DIV, XOR): A, B, C; offset ignored.
  - LW: A, C; offset must fit signed IMM_W. B field = offset[IMM_W-1 -: REG_SELECT]; imm[IMM_W-REG_SELECT-1:0] = offset low bits.
  - SW: A, B; imm = offset[IMM_W-1:0]; must fit signed IMM_W.
  - BEQ/BLT/BLE: A, B; offset[1:0] must be 00; offset>>>2 must fit signed IMM_W; imm = that value.
  - JMP: offset[1:0] must be 00; offset>>>2 must fit signed (32-OPCODES_WIDTH); written to bits [31-OPCODES_WIDTH:0].
  - NOP_OP: all fields zero.
- Error handling: unrecognised opcode or failed range/alignment check sets o_error (sticky until rst). The word is replaced by a zero-field NOP_OP word, so the address stays consistent.
- Encode stage: registered. A set accepted in cycle N is pushed into the FIFO at the edge ending N; o_mem_we can assert in N+1.
- FIFO and memory write:
  - o_mem_we = FIFO non-empty; o_mem_wdata/o_mem_addr are the head entry.
  - Write completes on o_mem_we && i_mem_ready: pop, o_mem_addr += 4, o_count += 1.
  - Address wraps modulo 2^ADDR_WIDTH.
  - o_ready = (state==RUN) && FIFO not full. Pop in the same cycle does not raise o_ready when full.
- FSM:
  - RUN: accepts field sets. On accepting one with i_last=1 -> FLUSH.
  - FLUSH: o_ready=0. When FIFO empty and encode stage empty -> DONE.
  - DONE: o_done=1 for one cycle; o_mem_addr <- BASE_ADDR; o_count <- 0 on next accept; -> RUN.
  - i_last on a single-instruction program works the same way (RUN->FLUSH at accept).
- Reset values: o_ready=0 during rst, 1 first cycle after. o_mem_we=0, o_mem_addr=BASE_ADDR, o_mem_wdata=0, o_count=0, o_done=0, o_error=0. State=RUN, FIFO empty.
- Reset mid-operation: FIFO and encode stage flushed and pending words dropped. Words already written are not retracted.

Optional Feature:
- ENCODER_ERR_HALT_EN
- Defined: an unencodable set is not written. It sets o_error, and the FSM enters HALT: o_ready=0, FIFO still drains, no o_done. Only rst exits HALT.
- Undefined: NOP substitution as above, with no HALT state.

Test Plan:
- ADD A=1 B=2 C=3, i_mem_ready=1 -> o_mem_we next cycle, addr=BASE_ADDR, word = {ADD_OP,5'd1,5'd2,5'd3,rest 0}; o_count=1.
- BEQ A=4 B=5 offset=8, then offset=6 -> first imm=2; second sets o_error and writes NOP_OP word at addr+4.
- SW A=2 B=7 offset=-4 -> imm field = low IMM_W bits of 32'hFFFFFFFC; LW C=9 A=3 offset=-1 -> B field all ones, low imm bits all ones, C=9.
- JMP offset=-8 -> bits [31-OPCODES_WIDTH:0] = low bits of -2.
- i_mem_ready=0 for 10 cycles while FIFO_DEPTH+2 sets are offered -> o_ready drops after FIFO_DEPTH+1 accepts; release -> sequential addresses, no loss or duplication.
- 3-instruction program, last with i_last=1 -> o_done one pulse after third write; next program restarts at BASE_ADDR. rst asserted mid-FLUSH -> all outputs at reset values asynchronously.
